// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, reset PC and bus layouts for the fetch stage.
//   FETCH_TO_DEC_BUS_WD : width of {inst, pc} sent to decode (64)
//   BR_BUS_WD           : width of {br_taken, br_target} from decode (33)
//   RESET_PC            : address of the first instruction fetched after reset
package inst_fetch_pkg;

  localparam int FETCH_TO_DEC_BUS_WD = 64;
  localparam int BR_BUS_WD           = 33;
  localparam logic [31:0] RESET_PC   = 32'h1c00_0000;

  typedef struct packed {
    logic        br_taken;
    logic [31:0] br_target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_bus_t;

endpackage

// File: rtl/fetch_inst_buf.sv
// fetch_inst_buf: one-entry instruction hold register for the fetch stage.
// Captures the SRAM read data on the first stall cycle so the SRAM can go
// idle while decode is stalled.
//   clk, reset    : clock, asynchronous active-high reset
//   capture       : load rdata and mark the buffer valid
//   clear         : drop the buffered word (transfer or redirect)
//   rdata         : instruction word from the SRAM
//   buf_valid     : buffer holds a word
//   buf_inst      : the buffered word
module fetch_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic        buf_valid,
  output logic [31:0] buf_inst
);

  // capture needs a stall and clear needs a transfer or redirect, so the two
  // never coincide; clear still wins for safety.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_inst  <= 32'b0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (capture) begin
      buf_valid <= 1'b1;
      buf_inst  <= rdata;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage (pre-IF next-PC generation + IF stage).
// Optional feature macro: FETCH_INST_BUF_EN adds a one-entry instruction
// buffer so the SRAM idles while decode stalls; without it the SRAM re-reads
// the held PC every stall cycle.
// Handshake: an instruction moves to decode on a rising edge where
// fetch_to_dec_valid and dec_allowin are both high; while dec_allowin is low
// the bus is held stable. A taken branch suppresses valid in that cycle.
//   clk, reset          : clock, asynchronous active-high reset
//   dec_allowin         : decode accepts an instruction this cycle
//   branch_bus          : {br_taken, br_target} from decode
//   fetch_to_dec_valid  : fetch_to_decode_bus holds a valid instruction
//   fetch_to_decode_bus : {inst, pc}
//   inst_sram_*         : synchronous instruction SRAM port (read only)
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_allowin,
  input  logic [BR_BUS_WD-1:0]           branch_bus,
  output logic                           fetch_to_dec_valid,
  output logic [FETCH_TO_DEC_BUS_WD-1:0] fetch_to_decode_bus,
  output logic                           inst_sram_en,
  output logic [3:0]                     inst_sram_we,
  output logic [31:0]                    inst_sram_addr,
  output logic [31:0]                    inst_sram_wdata,
  input  logic [31:0]                    inst_sram_rdata
);

  br_bus_t     br;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic [31:0] nextpc;
  logic        fs_allowin;
  fetch_bus_t  out_bus;

  assign br        = br_bus_t'(branch_bus);
  assign br_taken  = br.br_taken;
  assign br_target = br.br_target;

  // A redirect always opens IF: the held instruction is on the wrong path.
  assign fs_allowin = ~fs_valid | dec_allowin | br_taken;
  assign nextpc     = br_taken ? br_target : fs_pc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (fs_allowin) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end
  end

  assign fetch_to_dec_valid = fs_valid & ~br_taken;

  assign out_bus.inst        = fs_inst;
  assign out_bus.pc          = fs_pc;
  assign fetch_to_decode_bus = out_bus;

  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;

`ifdef FETCH_INST_BUF_EN
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic        buf_capture;
  logic        buf_clear;

  // First stall cycle: rdata still answers the read for fs_pc, grab it.
  assign buf_capture = fs_valid & ~fs_allowin & ~buf_valid;
  assign buf_clear   = br_taken | (fetch_to_dec_valid & dec_allowin);

  fetch_inst_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .capture   (buf_capture),
    .clear     (buf_clear),
    .rdata     (inst_sram_rdata),
    .buf_valid (buf_valid),
    .buf_inst  (buf_inst)
  );

  assign fs_inst        = buf_valid ? buf_inst : inst_sram_rdata;
  assign inst_sram_en   = ~reset & fs_allowin;
  assign inst_sram_addr = nextpc;
`else
  // No buffer: keep re-reading the held PC so rdata stays valid on a stall.
  assign fs_inst        = inst_sram_rdata;
  assign inst_sram_en   = ~reset;
  assign inst_sram_addr = fs_allowin ? nextpc : fs_pc;
`endif

endmodule
